// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions for the register-slave master.
// Contents:
//   htrans_t       - AHB transfer type encoding
//   register map   - ERR_STATUS / PAYLOAD / DATA_SIZE addresses
//   hsize values   - access size per register (all byte-wide)
//   mst_state_t    - master data-phase FSM states
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        NONSEQ = 2'd2,
        SEQ    = 2'd3
    } htrans_t;

    // Register map of the 8-bit slave
    localparam logic [2:0] ERR_STATUS = 3'd1;
    localparam logic [2:0] PAYLOAD    = 3'd2;
    localparam logic [2:0] DATA_SIZE  = 3'd4;

    // Every register is a byte; hsize encodes log2(bytes)
    localparam logic [2:0] HSIZE_BYTE       = 3'd0;
    localparam logic [2:0] HSIZE_ERR_STATUS = HSIZE_BYTE;
    localparam logic [2:0] HSIZE_PAYLOAD    = HSIZE_BYTE;
    localparam logic [2:0] HSIZE_DATA_SIZE  = HSIZE_BYTE;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,   // no data phase open
        S_DATA = 2'd1,   // data phase open, no error seen
        S_ERR1 = 2'd2,   // first ERROR cycle observed, pipelined address cancelled
        S_ERR2 = 2'd3    // ERROR response still being extended by the slave
    } mst_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with grant hold.
// Ports:
//   hclk, hreset_n - clock, async active-low reset
//   req[1:0]       - requester valids
//   hold           - granted address phase was driven but not accepted this cycle
//   advance        - granted address phase accepted this cycle
//   gnt_vld        - some requester is granted
//   gnt_id         - index of the granted requester
module rr_arbiter2 (
    input  logic       hclk,
    input  logic       hreset_n,
    input  logic [1:0] req,
    input  logic       hold,
    input  logic       advance,
    output logic       gnt_vld,
    output logic       gnt_id
);

    logic last_id;
    logic hold_vld;
    logic hold_id;

    always_comb begin
        gnt_vld = |req;
        gnt_id  = 1'b0;
        // A stalled address phase keeps its grant unless that requester
        // withdrew its command.
        if (hold_vld && req[hold_id])
            gnt_id = hold_id;
        else if (&req)
            gnt_id = ~last_id;
        else
            gnt_id = req[1];
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            last_id  <= 1'b1;   // so requester 0 wins the first contention
            hold_vld <= 1'b0;
            hold_id  <= 1'b0;
        end else begin
            if (advance)
                last_id <= gnt_id;
            hold_vld <= hold;
            if (hold)
                hold_id <= gnt_id;
        end
    end

endmodule

// File: rtl/ahb_req_arbiter_master.sv
// Two-requester AHB-Lite master for the 8-bit register slave.
// Arbitrates register commands round-robin and issues them as pipelined
// NONSEQ transfers; handles wait states, two-cycle ERROR responses and a
// stuck-bus watchdog.
// Ports:
//   hclk, hreset_n                      - clock, async active-low reset
//   req_valid/write/addr/size/wdata     - per-requester command
//   req_ready                           - one-hot pulse, address phase accepted
//   rsp_valid/rsp_rdata/rsp_err         - per-requester completion
//   wdog_trip                           - sticky stuck-bus flag
//   hsel_x/haddr/htrans/hsize/hwrite    - address phase to the slave
//   hwdata                              - data phase write data
//   hready                              - hready_in forwarded to slave
//   hready_in/hrdata/hresp              - slave response
module ahb_req_arbiter_master
    import ahb_pkg::*;
#(
    parameter int ADDR_W   = 3,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 16
) (
    input  logic                   hclk,
    input  logic                   hreset_n,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [1:0]             req_write,
    input  logic [1:0][ADDR_W-1:0] req_addr,
    input  logic [1:0][2:0]        req_size,
    input  logic [1:0][DATA_W-1:0] req_wdata,
    output logic [1:0]             rsp_valid,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   rsp_err,
    output logic                   wdog_trip,
    output logic                   hsel_x,
    output logic [ADDR_W-1:0]      haddr,
    output logic [1:0]             htrans,
    output logic [2:0]             hsize,
    output logic                   hwrite,
    output logic [DATA_W-1:0]      hwdata,
    output logic                   hready,
    input  logic                   hready_in,
    input  logic [DATA_W-1:0]      hrdata,
    input  logic                   hresp
);

    localparam int WCNT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;

    mst_state_t          state, state_nxt;
    logic                dp_id;
    logic                dp_write;
    logic [DATA_W-1:0]   dp_wdata;
    logic [WCNT_W-1:0]   wcnt;

    logic                gnt_vld;
    logic                gnt_id;
    logic                dp_open;
    logic                issue;
    logic                accept;
    logic                wd_fire;

    rr_arbiter2 u_arb (
        .hclk     (hclk),
        .hreset_n (hreset_n),
        .req      (req_valid),
        .hold     (issue && !hready_in),
        .advance  (accept),
        .gnt_vld  (gnt_vld),
        .gnt_id   (gnt_id)
    );

    assign dp_open = (state != S_IDLE);

    // New address phases only from IDLE/DATA; the ERROR states drive IDLE
    // to cancel whatever was pipelined. Reset gating keeps the bus quiet
    // immediately on assertion even if requesters still hold valid.
    assign issue   = hreset_n && !wdog_trip && gnt_vld &&
                     ((state == S_IDLE) || (state == S_DATA));
    assign accept  = issue && hready_in;

    // Fires in the MAX_WAIT-th consecutive stalled data-phase cycle.
    assign wd_fire = (state == S_DATA) && !hready_in &&
                     (wcnt == WCNT_W'(MAX_WAIT - 1));

    always_comb begin
        state_nxt = state;
        rsp_valid = '0;
        rsp_err   = 1'b0;
        rsp_rdata = '0;
        case (state)
            S_IDLE: begin
                if (accept)
                    state_nxt = S_DATA;
            end
            S_DATA: begin
                if (hready_in) begin
                    rsp_valid[dp_id] = 1'b1;
                    rsp_err          = hresp;
                    if (!dp_write && !hresp)
                        rsp_rdata = hrdata;
                    state_nxt = accept ? S_DATA : S_IDLE;
                end else if (hresp) begin
                    state_nxt = S_ERR1;
                end else if (wd_fire) begin
                    rsp_valid[dp_id] = 1'b1;
                    rsp_err          = 1'b1;
                    state_nxt        = S_IDLE;
                end
            end
            S_ERR1, S_ERR2: begin
                if (hready_in) begin
                    rsp_valid[dp_id] = 1'b1;
                    rsp_err          = 1'b1;
                    state_nxt        = S_IDLE;
                end else begin
                    state_nxt = S_ERR2;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state     <= S_IDLE;
            dp_id     <= 1'b0;
            dp_write  <= 1'b0;
            dp_wdata  <= '0;
            wcnt      <= '0;
            wdog_trip <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                dp_id    <= gnt_id;
                dp_write <= req_write[gnt_id];
                dp_wdata <= req_wdata[gnt_id];
            end
            if ((state == S_DATA) && !hready_in && !wd_fire)
                wcnt <= wcnt + 1'b1;
            else
                wcnt <= '0;
            if (wd_fire)
                wdog_trip <= 1'b1;
        end
    end

    always_comb begin
        htrans    = IDLE;
        haddr     = '0;
        hsize     = '0;
        hwrite    = 1'b0;
        req_ready = '0;
        if (issue) begin
            htrans = NONSEQ;
            haddr  = req_addr[gnt_id];
            hsize  = req_size[gnt_id];
            hwrite = req_write[gnt_id];
        end
        if (accept)
            req_ready[gnt_id] = 1'b1;
    end

    assign hwdata = dp_open ? dp_wdata : '0;
    assign hsel_x = issue || dp_open;
    assign hready = hready_in;

endmodule
